// File: rtl/cfs_algn_ctrl_if.sv
// RX-pop / TX-push handshake bundle between the aligner controller and its FIFOs.
// master = controller side, slave = FIFO side.
interface cfs_algn_ctrl_if #(
    parameter int unsigned ALGN_DATA_WIDTH = 32
);
    localparam int unsigned DATA_BYTES        = ALGN_DATA_WIDTH / 8;
    localparam int unsigned ALGN_OFFSET_WIDTH = (ALGN_DATA_WIDTH <= 8) ? 1 : $clog2(DATA_BYTES);
    localparam int unsigned ALGN_SIZE_WIDTH   = $clog2(DATA_BYTES) + 1;
    localparam int unsigned FIFO_WIDTH        = ALGN_DATA_WIDTH + ALGN_OFFSET_WIDTH + ALGN_SIZE_WIDTH;

    logic                  pop_valid;
    logic [FIFO_WIDTH-1:0] pop_data;
    logic                  pop_ready;
    logic                  push_valid;
    logic [FIFO_WIDTH-1:0] push_data;
    logic                  push_ready;

    modport master (
        input  pop_valid, pop_data, push_ready,
        output pop_ready, push_valid, push_data
    );

    modport slave (
        output pop_valid, pop_data, push_ready,
        input  pop_ready, push_valid, push_data
    );
endinterface

// File: rtl/cfs_algn_ctrl.sv
// Aligner controller: repacks unaligned RX beats into ctrl_size/ctrl_offset TX beats through a byte accumulator.
// Optional macro CFS_ALGN_CTRL_PARTIAL_FLUSH_EN: flush emits the residual bytes as one short final beat.
module cfs_algn_ctrl #(
    parameter  int unsigned ALGN_DATA_WIDTH   = 32,
    parameter  int unsigned ACC_BYTES         = 2 * ALGN_DATA_WIDTH / 8,
    localparam int unsigned DATA_BYTES        = ALGN_DATA_WIDTH / 8,
    localparam int unsigned ALGN_OFFSET_WIDTH = (ALGN_DATA_WIDTH <= 8) ? 1 : $clog2(DATA_BYTES),
    localparam int unsigned ALGN_SIZE_WIDTH   = $clog2(DATA_BYTES) + 1,
    localparam int unsigned ACC_CNT_WIDTH     = $clog2(ACC_BYTES + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    cfs_algn_ctrl_if.master              bus,
    input  logic [ALGN_OFFSET_WIDTH-1:0] ctrl_offset,
    input  logic [ALGN_SIZE_WIDTH-1:0]   ctrl_size,
    input  logic                         flush,
    output logic [ACC_CNT_WIDTH-1:0]     acc_count,
    output logic                         drop_pulse
);
    localparam int unsigned ACC_IDX_WIDTH = $clog2(ACC_BYTES);

    typedef struct packed {
        logic [ALGN_SIZE_WIDTH-1:0]   size;
        logic [ALGN_OFFSET_WIDTH-1:0] offset;
        logic [ALGN_DATA_WIDTH-1:0]   data;
    } beat_t;

    logic [7:0]               acc_q [ACC_BYTES];
    logic [7:0]               acc_d [ACC_BYTES];
    logic [ACC_CNT_WIDTH-1:0] acc_cnt_q, acc_cnt_d;
    logic                     push_valid_q, push_valid_d;
    beat_t                    push_data_q, push_data_d;
    logic                     drop_pulse_q, drop_pulse_d;
    logic                     flush_pending;

    beat_t       in_beat;
    logic [7:0]  in_bytes [DATA_BYTES];
    int unsigned in_size, in_off, c_size, c_off, cnt, rm_cnt, tail;
    logic        in_legal, ctrl_legal, space_ok, pop_fire, out_free, load, final_load;

    // Field decode and legality of the incoming beat and of the control setting
    always_comb begin
        in_beat    = bus.pop_data;
        in_size    = 32'(in_beat.size);
        in_off     = 32'(in_beat.offset);
        c_size     = 32'(ctrl_size);
        c_off      = 32'(ctrl_offset);
        cnt        = 32'(acc_cnt_q);
        in_legal   = (in_size != 0) && (in_off + in_size <= DATA_BYTES);
        ctrl_legal = (c_size != 0) && (c_off + c_size <= DATA_BYTES);
        space_ok   = (ACC_BYTES - cnt) >= DATA_BYTES;
        for (int unsigned k = 0; k < DATA_BYTES; k++) begin
            in_bytes[k] = in_beat.data[8*k +: 8];
        end
    end

    // Acceptance depends only on registered state plus reset/flush, never on pop_valid
    assign bus.pop_ready = !reset && !flush && !flush_pending && space_ok;
    assign pop_fire      = bus.pop_valid && bus.pop_ready;
    assign out_free      = !push_valid_q || bus.push_ready;

`ifdef CFS_ALGN_CTRL_PARTIAL_FLUSH_EN
    logic flush_pending_q, flush_pending_d;
    assign flush_pending = flush_pending_q;
`else
    assign flush_pending = 1'b0;
`endif

    // Next-state: head removal into the output register, tail append, flush
    always_comb begin
        acc_d        = acc_q;
        acc_cnt_d    = acc_cnt_q;
        push_valid_d = push_valid_q;
        push_data_d  = push_data_q;
        drop_pulse_d = pop_fire && !in_legal;
`ifdef CFS_ALGN_CTRL_PARTIAL_FLUSH_EN
        flush_pending_d = flush_pending_q;
        final_load      = out_free && flush_pending_q;
`else
        final_load      = 1'b0;
`endif
        load   = out_free && ctrl_legal && !flush_pending && (cnt >= c_size);
        rm_cnt = 0;

        if (load || final_load) begin
            rm_cnt             = load ? c_size : cnt;
            push_valid_d       = 1'b1;
            push_data_d.size   = ALGN_SIZE_WIDTH'(rm_cnt);
            push_data_d.offset = ctrl_offset;
            push_data_d.data   = '0;
            for (int unsigned j = 0; j < DATA_BYTES; j++) begin
                if ((j >= c_off) && ((j - c_off) < rm_cnt)) begin
                    push_data_d.data[8*j +: 8] = acc_q[ACC_IDX_WIDTH'(j - c_off)];
                end
            end
        end else if (bus.push_ready) begin
            push_valid_d = 1'b0;
        end

        // Removal works on pre-edge contents; a same-cycle pop lands after the shifted tail
        for (int unsigned i = 0; i < ACC_BYTES; i++) begin
            if (i + rm_cnt < ACC_BYTES) begin
                acc_d[ACC_IDX_WIDTH'(i)] = acc_q[ACC_IDX_WIDTH'(i + rm_cnt)];
            end else begin
                acc_d[ACC_IDX_WIDTH'(i)] = 8'h00;
            end
        end
        tail = cnt - rm_cnt;

        if (pop_fire && in_legal) begin
            for (int unsigned j = 0; j < DATA_BYTES; j++) begin
                if ((j < in_size) && (in_off + j < DATA_BYTES) && (tail + j < ACC_BYTES)) begin
                    acc_d[ACC_IDX_WIDTH'(tail + j)] = in_bytes[ALGN_OFFSET_WIDTH'(in_off + j)];
                end
            end
            acc_cnt_d = ACC_CNT_WIDTH'(tail + in_size);
        end else begin
            acc_cnt_d = ACC_CNT_WIDTH'(tail);
        end

        if (flush && !flush_pending) begin
`ifdef CFS_ALGN_CTRL_PARTIAL_FLUSH_EN
            if ((cnt != 0) && (cnt < c_size)) begin
                flush_pending_d = 1'b1;
            end else begin
                acc_cnt_d = '0;
            end
`else
            acc_cnt_d = '0;
`endif
        end

`ifdef CFS_ALGN_CTRL_PARTIAL_FLUSH_EN
        if (final_load) begin
            flush_pending_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < ACC_BYTES; i++) begin
                acc_q[i] <= 8'h00;
            end
            acc_cnt_q    <= '0;
            push_valid_q <= 1'b0;
            push_data_q  <= '0;
            drop_pulse_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            acc_cnt_q    <= acc_cnt_d;
            push_valid_q <= push_valid_d;
            push_data_q  <= push_data_d;
            drop_pulse_q <= drop_pulse_d;
        end
    end

`ifdef CFS_ALGN_CTRL_PARTIAL_FLUSH_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush_pending_q <= 1'b0;
        end else begin
            flush_pending_q <= flush_pending_d;
        end
    end
`endif

    assign bus.push_valid = push_valid_q;
    assign bus.push_data  = push_data_q;
    assign acc_count      = acc_cnt_q;
    assign drop_pulse     = drop_pulse_q;

    // A handshake must always leave room for a full input beat
    ap_no_overflow: assert property (@(posedge clk) disable iff (reset)
        pop_fire |-> (32'(acc_cnt_q) + DATA_BYTES <= ACC_BYTES));

    ap_cnt_bound: assert property (@(posedge clk) disable iff (reset)
        32'(acc_cnt_q) <= ACC_BYTES);

endmodule
